tx_medida_serial: RTL and testbench
===================================

# tx_medida_serial

Serial transmitter for a completed distance measurement. Sits directly downstream of the centimetre counter: when the counter reports a finished measurement, this block snapshots the three BCD digits. It then sends them over a UART line as ASCII text, hundreds digit first, followed by the '#' terminator (0x23). Each character uses 8N1 framing at a fixed, parameterised bit period.

## Interface

Parameters:
- M, default 434, clock cycles per serial bit (50 MHz / 115200 baud).
- N, default 9, width of the bit-period counter, equal to ceil(log2(M)).

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- partida  in  1  start request; normally driven by the counter's pronto.
- digito2  in  4  hundreds digit, BCD.
- digito1  in  4  tens digit, BCD.
- digito0  in  4  units digit, BCD.
- saida_serial  out  1  UART TX line; idle level is 1.
- ocupado  out  1  high while a message is being transmitted.
- pronto  out  1  one-cycle pulse when the message has been fully sent.
- db_estado  out  4  FSM state code, for debug.

## Operation

- FSM states and db_estado codes:
  - INICIAL = 0
  - TRANSMITE = 1
  - FINAL = F
- INICIAL:
  - saida_serial=1, ocupado=0.
  - On partida=1, latch digito2/1/0 into internal registers, clear all counters, go to TRANSMITE.
  - partida=0 keeps the FSM in INICIAL.
- Message content: four characters, sent in this order:
  - 0x30+digito2
  - 0x30+digito1
  - 0x30+digito0
  - 0x23
- Character codes use 8-bit addition. A digit above 9 is not checked or clamped; it is sent as-is (for example A gives 0x3A).
- Frame for each character, 10 bits in total:
  - start bit 0
  - 8 data bits, LSB first
  - stop bit 1
- The next character starts immediately after the previous stop bit; there is no idle gap.
- TRANSMITE: three counters run here.
  - Bit-period counter, 0..M-1. It advances every cycle and wraps at M-1.
  - Bit index, 0..9. It advances on each bit-period wrap.
  - Character index, 0..3. It advances when the bit index wraps past 9.
  - saida_serial is registered and driven from the current character and bit index.
- Exit from TRANSMITE: when character index 3, bit index 9 and bit-period M-1 coincide, go to FINAL.
- FINAL: lasts one cycle.
  - pronto=1, ocupado=0, saida_serial=1.
  - Then go unconditionally to INICIAL.
- partida is ignored in TRANSMITE and in FINAL; it is not queued.
- Input digits may change during a transmission. The latched copy is used, so the message always reflects the values present when partida was accepted.
- Reset from any state, including mid-character:
  - next cycle is INICIAL with saida_serial=1, ocupado=0, pronto=0, db_estado=0
  - counters are cleared
  - the partial frame is abandoned.
- Reset has priority over partida in the same cycle.

## Timing

- Values during and after reset: saida_serial=1, ocupado=0, pronto=0, db_estado=0.
- Cycle k is the cycle in which partida=1 is sampled in INICIAL.
- At k+1:
  - ocupado=1
  - saida_serial=0 (start bit of character 0)
  - db_estado=1
- Every serial bit holds for exactly M cycles. Bit j of character c occupies cycles k+1+(10c+j)·M through k+(10c+j+1)·M.
- Message length is exactly 40·M cycles, spanning k+1 to k+40·M.
- At k+40·M+1:
  - pronto=1 for one cycle
  - ocupado=0
  - db_estado=F
  - saida_serial=1
- At k+40·M+2: INICIAL; the earliest cycle in which a new partida is accepted.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Test plan

All scenarios use M=4, N=2.

- Basic message: after reset, digits 1,2,3, partida pulsed for 1 cycle.
  - Line sequence is 0x31, 0x32, 0x33, 0x23 in 8N1.
  - Character 0 bits: 0,1,0,0,0,1,1,0,0,1, each held 4 cycles.
  - pronto rises exactly 161 cycles after the partida cycle.
- Reset values: reset held for 3 cycles.
  - saida_serial=1, ocupado=0, pronto=0, db_estado=0 throughout.
- Input snapshot: send digits 0,0,7; change the digits to 9,9,9 at cycle k+10.
  - Transmitted bytes are 0x30, 0x30, 0x37, 0x23.
- partida while busy: pulse partida at k+50 and again in the FINAL cycle.
  - No second message; pronto pulses exactly once.
  - Line stays at 1 after the message ends.
- Reset mid-operation: assert reset at k+25, during character 0.
  - Next cycle: saida_serial=1, ocupado=0, no pronto.
  - A subsequent partida with digits 4,5,6 sends the full 0x34, 0x35, 0x36, 0x23.
- Non-BCD input: digits A,0,F.
  - Bytes sent are 0x3A, 0x30, 0x3F, 0x23.
  - Timing is identical to the basic message.

Source files
------------

// File: rtl/tx_medida_serial.sv
// UART transmitter for a finished distance measurement: snapshots three BCD
// digits and sends them as ASCII (hundreds first) followed by '#', 8N1.
module tx_medida_serial #(
   parameter int M = 434,
   parameter int N = 9
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [3:0] digito2,
   input  logic [3:0] digito1,
   input  logic [3:0] digito0,
   output logic       saida_serial,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL   = 4'h0,
      TRANSMITE = 4'h1,
      FINAL     = 4'hF
   } estado_t;

   estado_t           estado, estado_prox;
   logic [N-1:0]      cnt_tick, cnt_tick_prox;
   logic [3:0]        cnt_bit, cnt_bit_prox;
   logic [1:0]        cnt_char, cnt_char_prox;
   logic [2:0][3:0]   digs, digs_prox;
   logic              saida_q, saida_prox;
   logic              fim_tick, fim_bit, fim_msg;

   // Character c of the message; digits above 9 pass through unclamped.
   function automatic logic [7:0] codigo(input logic [2:0][3:0] d, input logic [1:0] c);
      logic [7:0] r;
      case (c)
         2'd0:    r = 8'h30 + {4'h0, d[2]};
         2'd1:    r = 8'h30 + {4'h0, d[1]};
         2'd2:    r = 8'h30 + {4'h0, d[0]};
         default: r = 8'h23;
      endcase
      return r;
   endfunction

   function automatic logic bit_quadro(input logic [7:0] car, input logic [3:0] idx);
      logic r;
      if (idx == 4'd0)
         r = 1'b0;
      else if (idx >= 4'd9)
         r = 1'b1;
      else
         r = car[3'(idx - 4'd1)];
      return r;
   endfunction

   assign fim_tick = (cnt_tick == N'(M - 1));
   assign fim_bit  = (cnt_bit == 4'd9);
   assign fim_msg  = fim_tick && fim_bit && (cnt_char == 2'd3);

   always_comb begin
      estado_prox   = estado;
      cnt_tick_prox = cnt_tick;
      cnt_bit_prox  = cnt_bit;
      cnt_char_prox = cnt_char;
      digs_prox     = digs;
      saida_prox    = 1'b1;
      case (estado)
         INICIAL: begin
            if (partida) begin
               estado_prox   = TRANSMITE;
               digs_prox     = {digito2, digito1, digito0};
               cnt_tick_prox = '0;
               cnt_bit_prox  = '0;
               cnt_char_prox = '0;
            end
         end
         TRANSMITE: begin
            if (fim_msg) begin
               estado_prox   = FINAL;
               cnt_tick_prox = '0;
               cnt_bit_prox  = '0;
               cnt_char_prox = '0;
            end else if (fim_tick) begin
               cnt_tick_prox = '0;
               if (fim_bit) begin
                  cnt_bit_prox  = '0;
                  cnt_char_prox = cnt_char + 2'd1;
               end else begin
                  cnt_bit_prox = cnt_bit + 4'd1;
               end
            end else begin
               cnt_tick_prox = cnt_tick + N'(1);
            end
         end
         FINAL:   estado_prox = INICIAL;
         default: estado_prox = INICIAL;
      endcase
      // Line is registered from the next-cycle position so the start bit
      // appears in the first TRANSMITE cycle.
      if (estado_prox == TRANSMITE)
         saida_prox = bit_quadro(codigo(digs_prox, cnt_char_prox), cnt_bit_prox);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= INICIAL;
         cnt_tick <= '0;
         cnt_bit  <= '0;
         cnt_char <= '0;
         digs     <= '0;
         saida_q  <= 1'b1;
      end else begin
         estado   <= estado_prox;
         cnt_tick <= cnt_tick_prox;
         cnt_bit  <= cnt_bit_prox;
         cnt_char <= cnt_char_prox;
         digs     <= digs_prox;
         saida_q  <= saida_prox;
      end
   end

   assign saida_serial = saida_q;
   assign ocupado      = (estado == TRANSMITE);
   assign pronto       = (estado == FINAL);
   assign db_estado    = estado;

endmodule

// File: tb/tb_tx_medida_serial.sv
// Self-checking bench for tx_medida_serial with M=4: per-cycle line/status
// compared against a frame-position model of the 4-character message.
module tb_tx_medida_serial;
   localparam int M   = 4;
   localparam int N   = 2;
   localparam int LEN = 40 * M;
   localparam int CAP = LEN + 24;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       partida = 1'b0;
   logic [3:0] digito2 = '0, digito1 = '0, digito0 = '0;
   logic       saida_serial, ocupado, pronto;
   logic [3:0] db_estado;

   int checks = 0;
   int failures = 0;

   logic       cap_l [0:CAP];
   logic       cap_o [0:CAP];
   logic       cap_p [0:CAP];
   logic [3:0] cap_e [0:CAP];

   tx_medida_serial #(.M(M), .N(N)) dut (
      .clock(clock), .reset(reset), .partida(partida),
      .digito2(digito2), .digito1(digito1), .digito0(digito0),
      .saida_serial(saida_serial), .ocupado(ocupado), .pronto(pronto),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // s = cycles after the cycle in which partida was sampled.
   function automatic logic exp_l(input logic [3:0][7:0] msg, input int s);
      int b, c, j;
      if (s < 1 || s > LEN) return 1'b1;
      b = (s - 1) / M;
      c = b / 10;
      j = b % 10;
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return msg[c][j-1];
   endfunction

   function automatic logic exp_o(input int s);
      return (s >= 1 && s <= LEN);
   endfunction

   function automatic logic exp_p(input int s);
      return (s == LEN + 1);
   endfunction

   function automatic logic [3:0] exp_e(input int s);
      if (s >= 1 && s <= LEN) return 4'h1;
      if (s == LEN + 1) return 4'hF;
      return 4'h0;
   endfunction

   function automatic logic [3:0][7:0] msg_of(input logic [3:0] d2, input logic [3:0] d1,
                                              input logic [3:0] d0);
      logic [3:0][7:0] m;
      m[0] = 8'h30 + {4'h0, d2};
      m[1] = 8'h30 + {4'h0, d1};
      m[2] = 8'h30 + {4'h0, d0};
      m[3] = 8'h23;
      return m;
   endfunction

   // Called just after a posedge; leaves us just after the next posedge (s=1).
   task automatic launch(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
      digito2 = d2; digito1 = d1; digito0 = d0;
      partida = 1'b1;
      @(posedge clock); #1;
      partida = 1'b0;
   endtask

   // Records outputs for s=1..n, optionally disturbing inputs at given cycles.
   task automatic capture(input int n, input int chg_s, input int p1, input int p2,
                          input int rst_s);
      for (int s = 1; s <= n; s++) begin
         if (s == chg_s) begin
            digito2 = 4'd9; digito1 = 4'd9; digito0 = 4'd9;
         end
         partida = (s == p1 || s == p2);
         reset   = (s == rst_s);
         cap_l[s] = saida_serial;
         cap_o[s] = ocupado;
         cap_p[s] = pronto;
         cap_e[s] = db_estado;
         @(posedge clock); #1;
      end
      partida = 1'b0;
      reset   = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; partida = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         checks++;
         if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'h0) begin
            failures++;
            $display("FAIL reset cyc=%0d got line=%b ocupado=%b pronto=%b estado=%h want 1 0 0 0",
                     i, saida_serial, ocupado, pronto, db_estado);
         end
      end
      reset = 1'b0; partida = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (saida_serial !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'h0) begin
         failures++;
         $display("FAIL reset_release got line=%b ocupado=%b pronto=%b estado=%h want 1 0 0 0",
                  saida_serial, ocupado, pronto, db_estado);
      end
   endtask

   task automatic test_basic;
      logic [3:0][7:0] msg;
      logic [9:0] c0;
      int first_p;
      msg = {8'h23, 8'h33, 8'h32, 8'h31};
      c0  = 10'b1001100010;
      launch(4'd1, 4'd2, 4'd3);
      capture(LEN + 4, -1, -1, -1, -1);
      for (int s = 1; s <= LEN + 4; s++) begin
         checks++;
         if (cap_l[s] !== exp_l(msg, s) || cap_o[s] !== exp_o(s) || cap_p[s] !== exp_p(s) || cap_e[s] !== exp_e(s)) begin
            failures++;
            $display("FAIL basic s=%0d got l/o/p/e=%b%b%b/%h want %b%b%b/%h", s,
                     cap_l[s], cap_o[s], cap_p[s], cap_e[s], exp_l(msg, s), exp_o(s), exp_p(s), exp_e(s));
         end
      end
      for (int j = 0; j < 10; j++)
         for (int q = 0; q < M; q++) begin
            checks++;
            if (cap_l[1 + j*M + q] !== c0[j]) begin
               failures++;
               $display("FAIL char0_bit j=%0d q=%0d got %b want %b", j, q, cap_l[1 + j*M + q], c0[j]);
            end
         end
      first_p = -1;
      for (int s = LEN + 4; s >= 1; s--)
         if (cap_p[s] === 1'b1) first_p = s;
      checks++;
      if (first_p != 161) begin
         failures++;
         $display("FAIL pronto_latency got %0d want 161", first_p);
      end
   endtask

   task automatic test_snapshot;
      logic [3:0][7:0] msg;
      msg = {8'h23, 8'h37, 8'h30, 8'h30};
      launch(4'd0, 4'd0, 4'd7);
      capture(LEN + 2, 10, -1, -1, -1);
      for (int s = 1; s <= LEN + 2; s++) begin
         checks++;
         if (cap_l[s] !== exp_l(msg, s) || cap_o[s] !== exp_o(s) || cap_p[s] !== exp_p(s)) begin
            failures++;
            $display("FAIL snapshot s=%0d got l/o/p=%b%b%b want %b%b%b", s,
                     cap_l[s], cap_o[s], cap_p[s], exp_l(msg, s), exp_o(s), exp_p(s));
         end
      end
   endtask

   task automatic test_busy;
      logic [3:0][7:0] msg;
      int np;
      msg = msg_of(4'd5, 4'd8, 4'd2);
      launch(4'd5, 4'd8, 4'd2);
      capture(CAP, -1, 50, LEN + 1, -1);
      np = 0;
      for (int s = 1; s <= CAP; s++) begin
         np += int'(cap_p[s] === 1'b1);
         checks++;
         if (cap_l[s] !== exp_l(msg, s) || cap_o[s] !== exp_o(s) || cap_p[s] !== exp_p(s) || cap_e[s] !== exp_e(s)) begin
            failures++;
            $display("FAIL busy s=%0d got l/o/p/e=%b%b%b/%h want %b%b%b/%h", s,
                     cap_l[s], cap_o[s], cap_p[s], cap_e[s], exp_l(msg, s), exp_o(s), exp_p(s), exp_e(s));
         end
      end
      checks++;
      if (np != 1) begin
         failures++;
         $display("FAIL busy_pronto_count got %0d want 1", np);
      end
   endtask

   task automatic test_reset_mid;
      logic [3:0][7:0] msg;
      logic el, eo;
      logic [3:0] ee;
      msg = msg_of(4'd8, 4'd8, 4'd8);
      launch(4'd8, 4'd8, 4'd8);
      capture(LEN + 4, -1, -1, -1, 25);
      for (int s = 1; s <= LEN + 4; s++) begin
         el = (s <= 25) ? exp_l(msg, s) : 1'b1;
         eo = (s <= 25);
         ee = (s <= 25) ? 4'h1 : 4'h0;
         checks++;
         if (cap_l[s] !== el || cap_o[s] !== eo || cap_p[s] !== 1'b0 || cap_e[s] !== ee) begin
            failures++;
            $display("FAIL reset_mid s=%0d got l/o/p/e=%b%b%b/%h want %b%b0/%h", s,
                     cap_l[s], cap_o[s], cap_p[s], cap_e[s], el, eo, ee);
         end
      end
      msg = {8'h23, 8'h36, 8'h35, 8'h34};
      launch(4'd4, 4'd5, 4'd6);
      capture(LEN + 2, -1, -1, -1, -1);
      for (int s = 1; s <= LEN + 2; s++) begin
         checks++;
         if (cap_l[s] !== exp_l(msg, s) || cap_o[s] !== exp_o(s) || cap_p[s] !== exp_p(s)) begin
            failures++;
            $display("FAIL after_reset s=%0d got l/o/p=%b%b%b want %b%b%b", s,
                     cap_l[s], cap_o[s], cap_p[s], exp_l(msg, s), exp_o(s), exp_p(s));
         end
      end
   endtask

   task automatic test_non_bcd;
      logic [3:0][7:0] msg;
      msg = {8'h23, 8'h3F, 8'h30, 8'h3A};
      launch(4'hA, 4'h0, 4'hF);
      capture(LEN + 3, -1, -1, -1, -1);
      for (int s = 1; s <= LEN + 3; s++) begin
         checks++;
         if (cap_l[s] !== exp_l(msg, s) || cap_o[s] !== exp_o(s) || cap_p[s] !== exp_p(s) || cap_e[s] !== exp_e(s)) begin
            failures++;
            $display("FAIL non_bcd s=%0d got l/o/p/e=%b%b%b/%h want %b%b%b/%h", s,
                     cap_l[s], cap_o[s], cap_p[s], cap_e[s], exp_l(msg, s), exp_o(s), exp_p(s), exp_e(s));
         end
      end
   endtask

   // Random digits, each message launched in the earliest accepted cycle.
   task automatic test_back_to_back;
      logic [3:0][7:0] msg;
      logic [3:0] d2, d1, d0;
      for (int r = 0; r < 6; r++) begin
         d2 = 4'($urandom_range(0, 15));
         d1 = 4'($urandom_range(0, 15));
         d0 = 4'($urandom_range(0, 15));
         msg = msg_of(d2, d1, d0);
         launch(d2, d1, d0);
         capture(LEN + 1, -1, -1, -1, -1);
         for (int s = 1; s <= LEN + 1; s++) begin
            checks++;
            if (cap_l[s] !== exp_l(msg, s) || cap_o[s] !== exp_o(s) || cap_p[s] !== exp_p(s) || cap_e[s] !== exp_e(s)) begin
               failures++;
               $display("FAIL back_to_back r=%0d digits=%h%h%h s=%0d got l/o/p/e=%b%b%b/%h want %b%b%b/%h",
                        r, d2, d1, d0, s, cap_l[s], cap_o[s], cap_p[s], cap_e[s],
                        exp_l(msg, s), exp_o(s), exp_p(s), exp_e(s));
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_snapshot;
      test_busy;
      test_reset_mid;
      test_non_bcd;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
